// File: rtl/mips32_pkg.sv
// Shared MIPS32 definitions: opcodes, register-file size and the R0 index,
// plus a decode helper telling whether an opcode writes its destination.
package mips32_pkg;

  localparam int          NREGS_DEFAULT = 32;
  localparam int unsigned R0_IDX        = 0;

  typedef enum logic [5:0] {
    OP_ADD   = 6'b000000,
    OP_SUB   = 6'b000001,
    OP_AND   = 6'b000010,
    OP_OR    = 6'b000011,
    OP_SLT   = 6'b000100,
    OP_MUL   = 6'b000101,
    OP_LW    = 6'b001000,
    OP_SW    = 6'b001001,
    OP_ADDI  = 6'b001010,
    OP_SUBI  = 6'b001011,
    OP_SLTI  = 6'b001100,
    OP_BNEQZ = 6'b001101,
    OP_BEQZ  = 6'b001110,
    OP_HLT   = 6'b111111
  } opcode_e;

  function automatic logic op_writes_rd(input opcode_e op);
    logic wr_s;
    case (op)
      OP_ADD, OP_SUB, OP_AND, OP_OR, OP_SLT, OP_MUL,
      OP_LW, OP_ADDI, OP_SUBI, OP_SLTI: wr_s = 1'b1;
      default:                          wr_s = 1'b0;
    endcase
    return wr_s;
  endfunction

endpackage

// File: rtl/mips32_pend_cnt.sv
// One pending-write counter: saturating up/down with a per-cycle underflow
// pulse when a retire arrives while nothing is pending.
module mips32_pend_cnt #(
  parameter int CW = 2
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          flush_i,
  input  logic          inc_i,
  input  logic          dec_i,
  output logic [CW-1:0] cnt_o,
  output logic          underflow_o
);

  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  // Flush wins over everything, so a retire in a flush cycle is simply dropped.
  always_comb begin
    cnt_d       = cnt_q;
    underflow_o = 1'b0;
    if (flush_i) begin
      cnt_d = {CW{1'b0}};
    end else begin
      case ({inc_i, dec_i})
        2'b10: begin
          if (cnt_q != {CW{1'b1}}) cnt_d = cnt_q + CW'(1);
          else                     cnt_d = cnt_q;
        end
        2'b01: begin
          if (cnt_q != {CW{1'b0}}) cnt_d = cnt_q - CW'(1);
          else                     underflow_o = 1'b1;
        end
        2'b11: begin
          if (cnt_q == {CW{1'b0}}) underflow_o = 1'b1;
          else                     cnt_d = cnt_q;
        end
        default: cnt_d = cnt_q;
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) cnt_q <= {CW{1'b0}};
    else        cnt_q <= cnt_d;
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/mips32_scoreboard.sv
// Register-hazard scoreboard: per-register in-flight write counters gate issue
// on RAW hazards and counter saturation; counts stall cycles.
module mips32_scoreboard
  import mips32_pkg::*;
#(
  parameter int NREGS     = NREGS_DEFAULT,
  parameter int AW        = $clog2(NREGS),
  parameter int CW        = 2,
  parameter int WB_BYPASS = 1,
  parameter int SCW       = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             issue_valid,
  input  logic [AW-1:0]    issue_rs,
  input  logic [AW-1:0]    issue_rt,
  input  logic             issue_use_rs,
  input  logic             issue_use_rt,
  input  logic [AW-1:0]    issue_rd,
  input  logic             issue_wr,
  output logic             issue_ready,
  input  logic             wb_valid,
  input  logic [AW-1:0]    wb_rd,
  input  logic             flush,
  output logic [NREGS-1:0] busy_mask,
  output logic [SCW-1:0]   stall_cnt,
  output logic             err_underflow
);

  localparam logic [AW-1:0] R0 = AW'(R0_IDX);

  logic [CW-1:0]    pend_s [NREGS];
  logic [NREGS-1:0] uf_s;
  logic             accept_s;
  logic             haz_rs_s;
  logic             haz_rt_s;
  logic             haz_sat_s;
  logic [SCW-1:0]   stall_cnt_q;
  logic [SCW-1:0]   stall_cnt_d;
  logic             err_q;
  logic             err_d;

  // A source whose sole pending write retires this cycle is forwarded when bypass is on.
  function automatic logic src_hazard(input logic use_s, input logic [AW-1:0] idx,
                                      input logic [CW-1:0] cnt, input logic wbv,
                                      input logic [AW-1:0] wbrd);
    logic haz_s;
    logic byp_s;
    haz_s = use_s && (idx != R0) && (cnt != {CW{1'b0}});
    byp_s = (WB_BYPASS != 0) && wbv && (wbrd == idx) && (cnt == CW'(1));
    return haz_s && !byp_s;
  endfunction

  assign pend_s[0] = {CW{1'b0}};
  assign uf_s[0]   = 1'b0;

  genvar gi;
  generate
    for (gi = 1; gi < NREGS; gi++) begin : g_pend
      mips32_pend_cnt #(.CW(CW)) u_cnt (
        .clk         (clk),
        .rst_n       (rst_n),
        .flush_i     (flush),
        .inc_i       (accept_s && issue_wr && (issue_rd == AW'(gi))),
        .dec_i       (wb_valid && (wb_rd == AW'(gi))),
        .cnt_o       (pend_s[gi]),
        .underflow_o (uf_s[gi])
      );
    end
    for (gi = 0; gi < NREGS; gi++) begin : g_busy
      assign busy_mask[gi] = (pend_s[gi] != {CW{1'b0}});
    end
  endgenerate

  // Hazard compare and issue gating; ready does not depend on issue_valid.
  always_comb begin
    haz_rs_s    = src_hazard(issue_use_rs, issue_rs, pend_s[issue_rs], wb_valid, wb_rd);
    haz_rt_s    = src_hazard(issue_use_rt, issue_rt, pend_s[issue_rt], wb_valid, wb_rd);
    haz_sat_s   = issue_wr && (issue_rd != R0) && (pend_s[issue_rd] == {CW{1'b1}});
    issue_ready = !flush && !haz_rs_s && !haz_rt_s && !haz_sat_s;
    accept_s    = issue_valid && issue_ready;
  end

  // Saturating stall counter and sticky underflow flag.
  always_comb begin
    stall_cnt_d = stall_cnt_q;
    err_d       = err_q | (|uf_s);
    if (issue_valid && !issue_ready && (stall_cnt_q != {SCW{1'b1}})) begin
      stall_cnt_d = stall_cnt_q + SCW'(1);
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cnt_q <= {SCW{1'b0}};
      err_q       <= 1'b0;
    end else begin
      stall_cnt_q <= stall_cnt_d;
      err_q       <= err_d;
    end
  end

  assign stall_cnt     = stall_cnt_q;
  assign err_underflow = err_q;

endmodule

// File: tb/tb_mips32_scoreboard.sv
// Directed bench for mips32_scoreboard: two instances (bypass on/off) share
// stimulus except issue_valid; expected values are hand-computed constants.
module tb_mips32_scoreboard;

  logic        clk = 1'b0;
  logic        rst_n;
  logic        iv1, iv0;
  logic [4:0]  rs, rt, rd, wbrd;
  logic        urs, urt, wr, wbv, fl;
  logic        rdy1, rdy0;
  logic [31:0] busy1, busy0;
  logic [31:0] stall1, stall0;
  logic        err1, err0;
  int          n_cmp = 0;
  int          n_err = 0;

  always #5 clk = ~clk;

  mips32_scoreboard #(.WB_BYPASS(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv1), .issue_rs(rs), .issue_rt(rt),
    .issue_use_rs(urs), .issue_use_rt(urt), .issue_rd(rd), .issue_wr(wr),
    .issue_ready(rdy1), .wb_valid(wbv), .wb_rd(wbrd), .flush(fl),
    .busy_mask(busy1), .stall_cnt(stall1), .err_underflow(err1)
  );

  mips32_scoreboard #(.WB_BYPASS(0)) dut0 (
    .clk(clk), .rst_n(rst_n), .issue_valid(iv0), .issue_rs(rs), .issue_rt(rt),
    .issue_use_rs(urs), .issue_use_rt(urt), .issue_rd(rd), .issue_wr(wr),
    .issue_ready(rdy0), .wb_valid(wbv), .wb_rd(wbrd), .flush(fl),
    .busy_mask(busy0), .stall_cnt(stall0), .err_underflow(err0)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_issue(input logic v, input logic w, input logic [4:0] d,
                           input logic us, input logic [4:0] s,
                           input logic ut, input logic [4:0] t);
    iv1 = v; wr = w; rd = d; urs = us; rs = s; urt = ut; rt = t;
  endtask

  initial begin
    rst_n = 1'b0; fl = 1'b0; wbv = 1'b0; wbrd = 5'd0;
    iv0 = 1'b1;
    set_issue(1'b1, 1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) tick();
    chk("rst_busy", busy1, 32'h0);
    chk("rst_stall", stall1, 32'd0);
    chk("rst_err", {31'd0, err1}, 32'd0);
    chk("rst_ready", {31'd0, rdy1}, 32'd1);
    rst_n = 1'b1;

    // RAW: ADDI R1,R0,imm then ADD R4,R1,R2; wb R1 at the third cycle after.
    set_issue(1'b1, 1'b1, 5'd1, 1'b1, 5'd0, 1'b0, 5'd0);
    iv0 = 1'b1;
    #1 chk("raw_addi_ready", {31'd0, rdy1}, 32'd1);
    tick();
    set_issue(1'b1, 1'b1, 5'd4, 1'b1, 5'd1, 1'b1, 5'd2);
    #1 chk("raw_stall1_ready", {31'd0, rdy1}, 32'd0);
    chk("raw_busy_r1", busy1, 32'h2);
    tick();
    #1 chk("raw_stall2_ready", {31'd0, rdy1}, 32'd0);
    tick();
    wbv = 1'b1; wbrd = 5'd1;
    #1 chk("raw_bypass_ready", {31'd0, rdy1}, 32'd1);
    chk("raw_nobypass_ready", {31'd0, rdy0}, 32'd0);
    tick();
    iv1 = 1'b0; wbv = 1'b0;
    #1 chk("raw_nobypass_late_ready", {31'd0, rdy0}, 32'd1);
    chk("raw_stall_bypass", stall1, 32'd2);
    chk("raw_stall_nobypass", stall0, 32'd3);
    chk("raw_busy_r4", busy1, 32'h10);
    tick();
    iv0 = 1'b0;
    wbv = 1'b1; wbrd = 5'd4;
    tick();
    wbv = 1'b0;
    chk("raw_clean", busy1, 32'h0);
    chk("raw_clean_nb", busy0, 32'h0);

    // Saturation on R5 with CW=2.
    set_issue(1'b1, 1'b1, 5'd5, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (3) tick();
    #1 chk("sat_ready", {31'd0, rdy1}, 32'd0);
    chk("sat_busy", busy1, 32'h20);
    tick();
    wbv = 1'b1; wbrd = 5'd5;
    #1 chk("sat_wb_cycle_ready", {31'd0, rdy1}, 32'd0);
    tick();
    wbv = 1'b0; iv1 = 1'b0;
    #1 chk("sat_after_wb_ready", {31'd0, rdy1}, 32'd1);
    chk("sat_stall", stall1, 32'd4);
    wbv = 1'b1; wbrd = 5'd5;
    repeat (2) tick();
    wbv = 1'b0;
    chk("sat_clean", busy1, 32'h0);

    // Simultaneous issue-write and wb on R3.
    set_issue(1'b1, 1'b1, 5'd3, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    wbv = 1'b1; wbrd = 5'd3;
    #1 chk("sim_ready", {31'd0, rdy1}, 32'd1);
    tick();
    iv1 = 1'b0; wbv = 1'b0;
    chk("sim_busy", busy1, 32'h8);
    wbv = 1'b1; wbrd = 5'd3;
    tick();
    wbv = 1'b0;
    chk("sim_clean", busy1, 32'h0);

    // Flush with pend[1]=2, pend[2]=1 and a concurrent wb R1.
    set_issue(1'b1, 1'b1, 5'd1, 1'b0, 5'd0, 1'b0, 5'd0);
    repeat (2) tick();
    rd = 5'd2;
    tick();
    chk("fl_pre_busy", busy1, 32'h6);
    rd = 5'd7; fl = 1'b1; wbv = 1'b1; wbrd = 5'd1;
    #1 chk("fl_ready", {31'd0, rdy1}, 32'd0);
    tick();
    fl = 1'b0; wbv = 1'b0; iv1 = 1'b0;
    #1 chk("fl_busy", busy1, 32'h0);
    chk("fl_err", {31'd0, err1}, 32'd0);
    chk("fl_stall", stall1, 32'd5);
    chk("fl_ready_after", {31'd0, rdy1}, 32'd1);

    // Underflow on R6, sticky.
    wbv = 1'b1; wbrd = 5'd6;
    tick();
    wbv = 1'b0;
    chk("uf_err", {31'd0, err1}, 32'd1);
    tick();
    chk("uf_sticky", {31'd0, err1}, 32'd1);

    // R0: never recorded, never a hazard.
    set_issue(1'b1, 1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 5'd0);
    #1 chk("r0_ready", {31'd0, rdy1}, 32'd1);
    tick();
    chk("r0_busy", busy1, 32'h0);

    // rt hazard on R9, cleared by bypass in the wb cycle.
    set_issue(1'b1, 1'b1, 5'd9, 1'b0, 5'd0, 1'b0, 5'd0);
    tick();
    set_issue(1'b0, 1'b0, 5'd0, 1'b1, 5'd0, 1'b1, 5'd9);
    #1 chk("rt_haz_ready", {31'd0, rdy1}, 32'd0);
    wbv = 1'b1; wbrd = 5'd9;
    #1 chk("rt_bypass_ready", {31'd0, rdy1}, 32'd1);
    wbv = 1'b0;

    // Asynchronous reset mid-operation clears state immediately.
    #2 rst_n = 1'b0;
    #1 chk("mid_rst_busy", busy1, 32'h0);
    chk("mid_rst_err", {31'd0, err1}, 32'd0);
    chk("mid_rst_stall", stall1, 32'd0);
    tick();
    rst_n = 1'b1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
